alu_result_stage: RTL
=====================

Name: alu_result_stage

Overview:
- EX/MEM boundary block. Consumes the ALU's result and flags (flags[2]=zero, flags[1]=negative, flags[0]=overflow) together with the instruction that produced them.
- Resolves beq/bne, raises the signed-overflow exception and decodes write-back/memory controls.
- Buffers everything behind a valid/ready handshake so the MEM stage can stall without losing an ALU result.

Parameters:
- DEPTH, 2, buffer entries (skid buffer); fixed at 2, any other value is unsupported.
- RESET_PC_EXC, 32'h0000_0000, exc_pc value after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  EX presents a valid ALU result
- in_ready  out  1  stage can accept this cycle
- instruction  in  32  instruction issued to the ALU
- pc_plus4  in  32  PC+4 of that instruction
- result  in  32  ALU result
- flags  in  3  ALU flags {zero,negative,overflow}
- store_data  in  32  rt value for sw
- out_valid  out  1  MEM entry valid
- out_ready  in  1  MEM accepts entry
- out_result  out  32  ALU result / memory address
- out_store_data  out  32  sw data
- out_dest  out  5  write-back register
- out_reg_write  out  1  write-back enable
- out_mem_read  out  1  lw
- out_mem_write  out  1  sw
- branch_taken  out  1  one-cycle pulse
- branch_target  out  32  valid with branch_taken
- ovf_exception  out  1  one-cycle pulse
- exc_pc  out  32  PC of faulting instruction, held until next exception

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset: all outputs 0 except exc_pc=RESET_PC_EXC. Buffer emptied. in_ready goes to 1 on the first cycle after rst_n rises.
- Reset mid-operation: buffered entries are discarded with no drain.
- Accept: accept = in_valid & in_ready.
- Transfer: xfer = out_valid & out_ready.
- Buffer: 2-entry FIFO, head drives the out_* signals, latency 1 cycle (entry accepted at edge N is visible after edge N).
- in_ready is registered: in_ready = (count<2) after the edge, i.e. it deasserts only when the buffer is full.
- Simultaneous accept+xfer with count=2: not possible (in_ready=0). With count=1: count stays 1, order preserved.
- Decode (opcode = instruction[31:26]):
  - R-type (opcode 0): dest = instr[15:11], reg_write=1.
  - I-type ALU (addi/addiu/slti/sltiu/andi/ori/xori) and lw: dest = instr[20:16], reg_write=1.
  - lw: mem_read=1.
  - sw: mem_write=1, reg_write=0.
  - beq/bne: reg_write=0, mem_*=0.
  - dest==0 forces reg_write=0.
- Branch (evaluated at accept only):
  - beq taken when flags[2]=1; bne taken when flags[2]=0.
  - branch_target = pc_plus4 + (sext(instr[15:0])<<2), mod 2^32.
  - branch_taken pulses for exactly one cycle after the accept edge, independent of out_ready.
  - Branches still enter the buffer (no-op entry).
- Overflow (evaluated at accept):
  - add (funct 100000), addi and sub (funct 100010) with flags[0]=1 cause an exception.
  - Effect: ovf_exception pulses one cycle, exc_pc = pc_plus4-4, entry enqueued with reg_write=0.
  - addu/addiu/subu never except, regardless of flags[0].
- Unrecognised opcode/funct: entry enqueued with all controls 0; no exception.
- Branch and overflow pulses never coincide (disjoint opcodes).

Decomposition:
- Shared package mips_defs_pkg holds:
  - opcode/funct localparams (OP_RTYPE, OP_ADDI, OP_BEQ, OP_BNE, OP_LW, OP_SW, FN_ADD, FN_SUB, ...)
  - flag index constants FLAG_ZERO=2, FLAG_NEG=1, FLAG_OVF=0
  - ctrl_t struct {dest, reg_write, mem_read, mem_write}
- Sub-module: ex_skid_fifo, a generic 2-entry valid/ready buffer parameterised by payload width; decode stays in the top.

Test Plan:
- add instr rd=3, result=0, flags=000, out_ready=1 -> next cycle out_valid=1, out_dest=3, out_reg_write=1, out_result=0.
- add with result=32'h00000002, flags=001, pc_plus4=0x104 -> ovf_exception one-cycle pulse, exc_pc=0x100, out_reg_write=0; same with addu -> no pulse, reg_write=1.
- beq imm=16'hFFFE, pc_plus4=0x200, flags=100 -> branch_taken pulse, branch_target=0x1F8; bne same flags -> no pulse.
- out_ready=0, three back-to-back accepts (results 1,2,3) -> in_ready drops after second accept, third held by EX; release out_ready -> outputs 1,2,3 in order, nothing lost or duplicated.
- lw rt=5, result=0x1000 -> out_mem_read=1, out_dest=5; sw with store_data=0xCAFE -> out_mem_write=1, out_reg_write=0, out_store_data=0xCAFE; addi with rt=0 -> out_reg_write=0.
- Two entries buffered, assert rst_n=0 one cycle -> out_valid=0, branch_taken=0, exc_pc=RESET_PC_EXC, in_ready=1 the cycle after release.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS encodings, ALU flag positions and the decoded control bundle
// carried from EX into MEM.
package mips_defs_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam int FLAG_ZERO = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_OVF  = 0;

  typedef struct packed {
    logic [4:0] dest;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // R-type functs that write rd; anything else is treated as a no-op entry.
  function automatic logic funct_writes_rd(input logic [5:0] fn);
    logic hit;
    hit = 1'b0;
    case (fn)
      FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ex_skid_fifo.sv
// Two-entry valid/ready buffer; head entry drives the output, ready is
// registered and drops only when both slots are occupied.
module ex_skid_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         ready_q;
  logic         accept;
  logic         xfer;

  assign accept = in_valid_i & ready_q;
  assign xfer   = (count_q != 2'd0) & out_ready_i;

  always_comb begin
    count_d = count_q;
    case ({accept, xfer})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (xfer) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
      ready_q <= (count_d < FULL);
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/alu_result_stage.sv
// EX/MEM boundary: decodes write-back/memory controls, resolves beq/bne and
// signed-overflow traps at accept time, and buffers results for MEM stalls.
module alu_result_stage
  import mips_defs_pkg::*;
#(
  parameter int          DEPTH        = 2,
  parameter logic [31:0] RESET_PC_EXC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instruction,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] result,
  input  logic [2:0]  flags,
  input  logic [31:0] store_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [31:0] out_store_data,
  output logic [4:0]  out_dest,
  output logic        out_reg_write,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        ovf_exception,
  output logic [31:0] exc_pc
);

  localparam int PAYLOAD_W = 64 + CTRL_W;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  ctrl_t       ctrl_d;
  ctrl_t       ctrl_out;
  logic        ovf_d;
  logic        br_taken_d;
  logic [31:0] br_target_d;
  logic        accept;

  logic        branch_taken_q;
  logic [31:0] branch_target_q;
  logic        ovf_exception_q;
  logic [31:0] exc_pc_q;

  logic [PAYLOAD_W-1:0] payload_in;
  logic [PAYLOAD_W-1:0] payload_out;

  logic unused_bits;
  assign unused_bits = ^{instruction[25:21], flags[FLAG_NEG]};

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign accept = in_valid & in_ready;

  always_comb begin
    ctrl_d     = '0;
    ovf_d      = 1'b0;
    br_taken_d = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (funct_writes_rd(funct)) begin
          ctrl_d.dest      = rd;
          ctrl_d.reg_write = 1'b1;
          ovf_d = ((funct == FN_ADD) || (funct == FN_SUB)) & flags[FLAG_OVF];
        end
      end
      OP_ADDI: begin
        ctrl_d.dest      = rt;
        ctrl_d.reg_write = 1'b1;
        ovf_d            = flags[FLAG_OVF];
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl_d.dest      = rt;
        ctrl_d.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl_d.dest      = rt;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.mem_read  = 1'b1;
      end
      OP_SW:   ctrl_d.mem_write = 1'b1;
      OP_BEQ:  br_taken_d = flags[FLAG_ZERO];
      OP_BNE:  br_taken_d = ~flags[FLAG_ZERO];
      default: ctrl_d = '0;
    endcase
    // A trapping add/sub must not retire, and $zero is never written.
    if ((ctrl_d.dest == 5'd0) || ovf_d) ctrl_d.reg_write = 1'b0;
  end

  assign br_target_d = pc_plus4 + {{14{instruction[15]}}, instruction[15:0], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_taken_q  <= 1'b0;
      branch_target_q <= 32'd0;
      ovf_exception_q <= 1'b0;
      exc_pc_q        <= RESET_PC_EXC;
    end else begin
      branch_taken_q  <= accept & br_taken_d;
      ovf_exception_q <= accept & ovf_d;
      if (accept & br_taken_d) branch_target_q <= br_target_d;
      if (accept & ovf_d)      exc_pc_q        <= pc_plus4 - 32'd4;
    end
  end

  assign payload_in = {result, store_data, ctrl_d};

  ex_skid_fifo #(
    .W     (PAYLOAD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (payload_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (payload_out)
  );

  assign {out_result, out_store_data, ctrl_out} = payload_out;
  assign out_dest      = ctrl_out.dest;
  assign out_reg_write = ctrl_out.reg_write;
  assign out_mem_read  = ctrl_out.mem_read;
  assign out_mem_write = ctrl_out.mem_write;
  assign branch_taken  = branch_taken_q;
  assign branch_target = branch_target_q;
  assign ovf_exception = ovf_exception_q;
  assign exc_pc        = exc_pc_q;

endmodule
